miriscv_mdu_seq: RTL and testbench

- Sequencer for iterative multiply/divide in the execute stage. Started by the decoder's MDU request, operation select and the RS1/RS2 operands.
- Holds the pipeline via a stall request while it runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Handles RV32M corner cases in a single cycle.
- Returns one registered result per accepted request. Supports kill from pipeline flush.

---
 rtl/miriscv_mdu_seq.sv | 113 +++++++++++
 tb/tb_miriscv_mdu_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/miriscv_mdu_seq.sv
// miriscv_mdu_seq: iterative RV32M multiply/divide sequencer with single-cycle corner cases.
package miriscv_mdu_pkg;
  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;
endpackage

module miriscv_mdu_seq
  import miriscv_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MDU_OP_W = 3
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                mdu_req_i,
  input  logic [MDU_OP_W-1:0] mdu_op_i,
  input  logic [XLEN-1:0]     mdu_port_a_i,
  input  logic [XLEN-1:0]     mdu_port_b_i,
  input  logic                mdu_kill_i,
  output logic                mdu_stall_req_o,
  output logic                mdu_valid_o,
  output logic [XLEN-1:0]     mdu_result_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t              state;
  logic [MDU_OP_W-1:0] op;
  logic                neg_q, neg_r;
  logic [XLEN-1:0]     opd;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       cnt;
  logic                is_div, sa, sb, na, nb, b_zero, ovf, special, accept;
  logic [XLEN-1:0]     abs_a, abs_b, spec_res, q, r, fix_res;
  logic [XLEN:0]       madd, dsub;
  logic [2*XLEN-1:0]   mul_nxt, div_nxt, p;
  always_comb begin
    is_div   = mdu_op_i[2];
    sa       = mdu_op_i inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    sb       = mdu_op_i inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    na       = sa & mdu_port_a_i[XLEN-1];
    nb       = sb & mdu_port_b_i[XLEN-1];
    abs_a    = na ? -mdu_port_a_i : mdu_port_a_i;
    abs_b    = nb ? -mdu_port_b_i : mdu_port_b_i;
    b_zero   = mdu_port_b_i == '0;
    ovf      = (mdu_op_i == MDU_DIV || mdu_op_i == MDU_REM) && mdu_port_a_i == MIN_INT && mdu_port_b_i == '1;
    special  = is_div & (b_zero | ovf);
    spec_res = b_zero ? (mdu_op_i[1] ? mdu_port_a_i : '1) : (mdu_op_i[1] ? '0 : MIN_INT);
    accept   = state == IDLE && mdu_req_i && !mdu_kill_i;
    madd     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    mul_nxt  = {madd, acc[XLEN-1:1]};
    // restoring step: trial-subtract the divisor from the shifted partial remainder
    dsub     = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
    div_nxt  = dsub[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {dsub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    p        = neg_q ? -acc : acc;
    q        = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r        = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_res  = op[2] ? (op[1] ? r : q) : (op == MDU_MUL ? p[XLEN-1:0] : p[2*XLEN-1:XLEN]);
  end
  assign mdu_stall_req_o = !mdu_kill_i && (accept || state == CALC || state == FIX);
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= IDLE;
      op           <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      opd          <= '0;
      acc          <= '0;
      cnt          <= '0;
      mdu_valid_o  <= 1'b0;
      mdu_result_o <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op    <= mdu_op_i;
          neg_q <= na ^ nb;
          neg_r <= na;
          opd   <= is_div ? abs_b : abs_a;
          acc   <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
          cnt   <= '0;
          state <= special ? DONE : CALC;
          if (special) begin
            mdu_result_o <= spec_res;
            mdu_valid_o  <= 1'b1;
          end
        end
        CALC: if (mdu_kill_i) state <= IDLE;
        else begin
          acc <= op[2] ? div_nxt : mul_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) state <= FIX;
        end
        FIX: if (mdu_kill_i) state <= IDLE;
        else begin
          mdu_result_o <= fix_res;
          mdu_valid_o  <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          mdu_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_miriscv_mdu_seq.sv
// tb_miriscv_mdu_seq: scoreboard bench for the MDU sequencer with directed RV32M vectors.
module tb_miriscv_mdu_seq;
  import miriscv_mdu_pkg::*;
  logic clk = 0, arst = 1, req = 0, kill = 0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic stall, valid;
  logic [31:0] res;
  int cyc = 0, checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  int cyc_q[$];
  logic [31:0] last = '0;
  logic prev_valid = 0;

  miriscv_mdu_seq #(.XLEN(32), .MDU_OP_W(3)) dut (
    .clk_i(clk), .arst_i(arst), .mdu_req_i(req), .mdu_op_i(op),
    .mdu_port_a_i(a), .mdu_port_b_i(b), .mdu_kill_i(kill),
    .mdu_stall_req_o(stall), .mdu_valid_o(valid), .mdu_result_o(res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, e, cyc);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e, input int lat);
    op = o; a = x; b = y; req = 1;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + lat);
    last = e;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk("stall", 32'(stall), 32'(k < lat));
      @(posedge clk); #1;
    end
    req = 0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (valid) begin
        if (prev_valid) chk("valid_twice", 32'(prev_valid), 32'(0));
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(valid), 32'(0));
        else begin
          chk("result", res, exp_q.pop_front());
          chk("valid_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
        end
      end
      prev_valid = valid;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0;
    #1;
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_result", res, 32'h0);
    chk("rst_stall", 32'(stall), 32'(0));
    @(negedge clk); arst = 0;
    @(posedge clk); #1;
    run(MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run(MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
    run(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run(MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run(MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run(MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run(MDU_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34);
    run(MDU_REMU,   32'd100,      32'd7,        32'd2,        34);
    run(MDU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run(MDU_REMU,   32'd5,        32'd0,        32'd5,        1);
    run(MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run(MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
    run(MDU_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1);
    run(MDU_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34);
    op = MDU_DIV; a = 32'd100; b = 32'd7; req = 1;
    c0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    kill = 1;
    @(negedge clk);
    chk("kill_stall", 32'(stall), 32'(0));
    chk("kill_cycle", 32'(cyc - c0), 32'd10);
    @(posedge clk); #1;
    kill = 0; req = 0;
    chk("kill_hold", res, last);
    run(MDU_MUL, 32'd3, 32'd4, 32'd12, 34);
    op = MDU_MUL; a = 32'd5; b = 32'd6; req = 1;
    repeat (15) @(posedge clk);
    #2;
    req = 0; arst = 1;
    #1;
    chk("arst_stall", 32'(stall), 32'(0));
    chk("arst_valid", 32'(valid), 32'(0));
    chk("arst_result", res, 32'h0);
    @(negedge clk); arst = 0;
    @(posedge clk); #1;
    run(MDU_MUL, 32'd2, 32'd2, 32'd4, 34);
    repeat (3) @(posedge clk);
    #1;
    chk("pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
